// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared constants for the forwarding scoreboard
package fwd_scoreboard_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int NO_FWD     = 0;
    localparam int STG_EX     = 1;
    localparam int STG_MEM    = 2;
    localparam int MAX_DEPTH  = 7;
    localparam int CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Largest stage index a select field of the given width can encode.
    function automatic int sel_max_stage(input int sel_w);
        return (1 << sel_w) - 1;
    endfunction

endpackage

// File: rtl/fwd_match_src.sv
// rtl/fwd_match_src.sv - priority matcher for one ID source operand
module fwd_match_src
    import fwd_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int LOAD_RDY = STG_MEM,
    parameter int SEL_W    = 3
) (
    input  logic                    id_valid,
    input  logic                    src_used,
    input  logic [ADDR_W-1:0]       src_addr,
    input  logic [DEPTH-1:0]        ent_valid,
    input  logic [DEPTH-1:0]        ent_wr,
    input  logic [DEPTH-1:0]        ent_load,
    input  logic [DEPTH*ADDR_W-1:0] ent_addr,
    output logic [SEL_W-1:0]        sel,
    output logic                    not_ready
);

    logic [DEPTH-1:0] hit;

    always_comb begin
        hit = '0;
        for (int s = 0; s < DEPTH; s++) begin
            hit[s] = id_valid & src_used & ent_valid[s] & ent_wr[s]
                   & (ent_addr[s*ADDR_W +: ADDR_W] != '0)
                   & (ent_addr[s*ADDR_W +: ADDR_W] == src_addr);
        end
    end

    // Walk oldest to youngest so the youngest producer is the last assignment.
    always_comb begin
        sel       = SEL_W'(NO_FWD);
        not_ready = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (hit[s]) begin
                sel       = SEL_W'(s + 1);
                not_ready = ent_load[s] && ((s + 1) < LOAD_RDY);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight write tracker with forwarding select and load-use stall
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_RDY = STG_MEM,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [ADDR_W-1:0]         id_dst_addr,
    input  logic                      id_wr_en,
    input  logic                      id_is_load,
    input  logic                      hold,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    generate
        if (DEPTH < STG_EX || DEPTH > MAX_DEPTH || LOAD_RDY < STG_EX ||
            LOAD_RDY > DEPTH || DEPTH > sel_max_stage(SEL_W)) begin : g_bad_cfg
            $error("fwd_scoreboard: illegal DEPTH/LOAD_RDY/SEL_W combination");
        end
    endgenerate

    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_wr;
    logic [DEPTH-1:0]        ent_load;
    logic [DEPTH*ADDR_W-1:0] ent_addr;
    logic [NUM_SRC-1:0]      not_ready;
    logic                    take_id;
    logic [CNT_W-1:0]        cnt_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match_src #(
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .LOAD_RDY (LOAD_RDY),
            .SEL_W    (SEL_W)
        ) u_match (
            .id_valid  (id_valid),
            .src_used  (id_src_used[i]),
            .src_addr  (id_src_addr[i*ADDR_W +: ADDR_W]),
            .ent_valid (ent_valid),
            .ent_wr    (ent_wr),
            .ent_load  (ent_load),
            .ent_addr  (ent_addr),
            .sel       (fwd_sel[i*SEL_W +: SEL_W]),
            .not_ready (not_ready[i])
        );
    end

    assign stall   = |not_ready;
    assign take_id = ~flush & ~stall;

    // Stage 1 loads on flush even under hold; older stages only move without hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            ent_wr    <= '0;
            ent_load  <= '0;
            ent_addr  <= '0;
        end else begin
            if (flush || !hold) begin
                ent_valid[0]         <= take_id & id_valid;
                ent_wr[0]            <= take_id & id_valid & id_wr_en;
                ent_load[0]          <= take_id & id_is_load;
                ent_addr[0 +: ADDR_W] <= take_id ? id_dst_addr : '0;
            end
            if (!hold) begin
                for (int s = 1; s < DEPTH; s++) begin
                    ent_valid[s]               <= ent_valid[s-1];
                    ent_wr[s]                  <= ent_wr[s-1];
                    ent_load[s]                <= ent_load[s-1];
                    ent_addr[s*ADDR_W +: ADDR_W] <= ent_addr[(s-1)*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && !hold && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - scoreboard bench for fwd_scoreboard in three configurations
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [8:0]  sel;
        bit          care;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    // default configuration
    logic        a_rst, a_valid, a_wr, a_load, a_hold, a_flush, a_stall;
    logic [9:0]  a_src;
    logic [1:0]  a_used;
    logic [4:0]  a_dst;
    logic [5:0]  a_sel;
    logic [15:0] a_cnt;

    // three sources, four stages, loads ready at stage 3
    logic        b_rst, b_valid, b_wr, b_load, b_hold, b_flush, b_stall;
    logic [14:0] b_src;
    logic [2:0]  b_used;
    logic [4:0]  b_dst;
    logic [8:0]  b_sel;
    logic [15:0] b_cnt;

    // one source, seven stages, loads ready at stage 7
    logic        c_rst, c_valid, c_wr, c_load, c_hold, c_flush, c_stall;
    logic [4:0]  c_src;
    logic [0:0]  c_used;
    logic [4:0]  c_dst;
    logic [2:0]  c_sel;
    logic [15:0] c_cnt;

    fwd_scoreboard u_a (
        .clk(clk), .rst(a_rst), .id_valid(a_valid), .id_src_addr(a_src),
        .id_src_used(a_used), .id_dst_addr(a_dst), .id_wr_en(a_wr),
        .id_is_load(a_load), .hold(a_hold), .flush(a_flush),
        .fwd_sel(a_sel), .stall(a_stall), .stall_cnt(a_cnt)
    );

    fwd_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_RDY(3)) u_b (
        .clk(clk), .rst(b_rst), .id_valid(b_valid), .id_src_addr(b_src),
        .id_src_used(b_used), .id_dst_addr(b_dst), .id_wr_en(b_wr),
        .id_is_load(b_load), .hold(b_hold), .flush(b_flush),
        .fwd_sel(b_sel), .stall(b_stall), .stall_cnt(b_cnt)
    );

    fwd_scoreboard #(.NUM_SRC(1), .DEPTH(7), .LOAD_RDY(7)) u_c (
        .clk(clk), .rst(c_rst), .id_valid(c_valid), .id_src_addr(c_src),
        .id_src_used(c_used), .id_dst_addr(c_dst), .id_wr_en(c_wr),
        .id_is_load(c_load), .hold(c_hold), .flush(c_flush),
        .fwd_sel(c_sel), .stall(c_stall), .stall_cnt(c_cnt)
    );

    function automatic logic [8:0] sv(input logic [2:0] s0, input logic [2:0] s1,
                                      input logic [2:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int dut, input logic [8:0] sel,
                        input bit care, input logic stall, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.dut = dut; e.sel = sel; e.care = care; e.stall = stall; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Compare at the falling edge, then move just past the next rising edge.
    task automatic step();
        exp_t        e;
        logic [8:0]  gs;
        logic        gst;
        logic [15:0] gc;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.dut)
                0:       begin gs = {3'b0, a_sel}; gst = a_stall; gc = a_cnt; end
                1:       begin gs = b_sel;         gst = b_stall; gc = b_cnt; end
                default: begin gs = {6'b0, c_sel}; gst = c_stall; gc = c_cnt; end
            endcase
            if (e.care) check({e.tag, ".sel"}, 32'(gs), 32'(e.sel));
            check({e.tag, ".stall"}, 32'(gst), 32'(e.stall));
            check({e.tag, ".cnt"}, 32'(gc), 32'(e.cnt));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] dst,
                        input logic wr, input logic ld);
        a_valid = v; a_src = {s1, s0}; a_used = used; a_dst = dst; a_wr = wr; a_load = ld;
    endtask

    task automatic b_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] used, input logic [4:0] dst,
                        input logic wr, input logic ld);
        b_valid = v; b_src = {s2, s1, s0}; b_used = used; b_dst = dst; b_wr = wr; b_load = ld;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        int   raw;
        bit   near_done;
        logic st_exp;

        a_rst = 1'b1; a_hold = 1'b0; a_flush = 1'b0; a_id(0, 0, 0, 0, 0, 0, 0);
        b_rst = 1'b1; b_hold = 1'b0; b_flush = 1'b0; b_id(0, 0, 0, 0, 0, 0, 0, 0);
        c_rst = 1'b1; c_hold = 1'b0; c_flush = 1'b0;
        c_valid = 1'b0; c_src = 5'd0; c_used = 1'b0; c_dst = 5'd0; c_wr = 1'b0; c_load = 1'b0;
        @(posedge clk);
        #1;
        push("a_reset", 0, 9'd0, 1, 0, 16'd0);
        push("b_reset", 1, 9'd0, 1, 0, 16'd0);
        push("c_reset", 2, 9'd0, 1, 0, 16'd0);
        step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // back-to-back ALU forwarding
        a_id(1, 3, 0, 2'b00, 3, 1, 0); push("alu_prod", 0, 9'd0, 1, 0, 16'd0); step();
        a_id(1, 3, 0, 2'b01, 6, 1, 0); push("alu_ex", 0, sv(1, 0, 0), 1, 0, 16'd0); step();
        a_id(1, 3, 6, 2'b11, 0, 0, 0); push("alu_mem", 0, sv(2, 1, 0), 1, 0, 16'd0); step();

        // load-use: one stall, then forward from stage 2
        a_id(1, 0, 0, 2'b00, 5, 1, 1); push("lw_issue", 0, 9'd0, 1, 0, 16'd0); step();
        a_id(1, 5, 0, 2'b01, 7, 1, 0); push("lu_stall", 0, 9'd0, 0, 1, 16'd0); step();
        push("lu_fwd", 0, sv(2, 0, 0), 1, 0, 16'd1); step();

        // youngest producer wins; register 0 never matches
        a_id(1, 0, 0, 2'b00, 7, 1, 0); push("r7_second", 0, 9'd0, 1, 0, 16'd1); step();
        a_id(1, 7, 7, 2'b11, 0, 1, 0); push("prio_r7", 0, sv(1, 1, 0), 1, 0, 16'd1); step();
        a_id(1, 0, 0, 2'b11, 0, 1, 1); push("r0_alu", 0, 9'd0, 1, 0, 16'd1); step();
        a_id(1, 0, 0, 2'b11, 0, 0, 0); push("r0_load", 0, 9'd0, 1, 0, 16'd1); step();

        // hold during a load-use stall freezes state and counter
        a_id(1, 0, 0, 2'b00, 5, 1, 1); push("lw5_issue", 0, 9'd0, 1, 0, 16'd1); step();
        a_id(1, 5, 0, 2'b01, 8, 1, 0);
        a_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("hold_stall", 0, 9'd0, 0, 1, 16'd1); step();
        end
        a_hold = 1'b0;
        push("hold_rel", 0, 9'd0, 0, 1, 16'd1); step();
        push("hold_after", 0, sv(2, 0, 0), 1, 0, 16'd2); step();

        // flush bubbles stage 1 and lets the load move on
        a_id(1, 0, 0, 2'b00, 4, 1, 1); push("lw4_issue", 0, 9'd0, 1, 0, 16'd2); step();
        a_id(1, 4, 0, 2'b01, 9, 1, 0);
        a_flush = 1'b1; push("flush_stall", 0, 9'd0, 0, 1, 16'd2); step();
        a_flush = 1'b0; push("post_flush", 0, sv(2, 0, 0), 1, 0, 16'd3); step();
        a_id(1, 4, 0, 2'b01, 0, 0, 0); push("flush_gone", 0, 9'd0, 1, 0, 16'd3); step();

        // reset in the middle of a stall
        a_id(1, 0, 0, 2'b00, 5, 1, 1); push("lw5b_issue", 0, 9'd0, 1, 0, 16'd3); step();
        a_id(1, 5, 0, 2'b01, 10, 1, 0);
        a_rst = 1'b1; push("rst_stall", 0, 9'd0, 0, 1, 16'd3); step();
        a_rst = 1'b0; push("rst_after", 0, 9'd0, 1, 0, 16'd0); step();

        // deeper pipeline: two stall cycles, forward from stage 3 then 4, then dropped
        b_id(1, 0, 0, 0, 3'b000, 9, 1, 1); push("b_lw9", 1, 9'd0, 1, 0, 16'd0); step();
        b_id(1, 2, 9, 9, 3'b101, 2, 1, 0); push("b_stall1", 1, 9'd0, 0, 1, 16'd0); step();
        push("b_stall2", 1, 9'd0, 0, 1, 16'd1); step();
        push("b_fwd3", 1, sv(0, 0, 3), 1, 0, 16'd2); step();
        b_id(1, 2, 0, 9, 3'b101, 0, 0, 0); push("b_fwd4", 1, sv(1, 0, 4), 1, 0, 16'd2); step();
        b_id(1, 9, 2, 0, 3'b011, 0, 0, 0); push("b_drop", 1, sv(0, 2, 0), 1, 0, 16'd2); step();

        // saturation: repeated lw r9,0(r9) stalls six of every seven cycles
        c_valid = 1'b1; c_src = 5'd9; c_used = 1'b1; c_dst = 5'd9; c_wr = 1'b1; c_load = 1'b1;
        c = 0; raw = 0; near_done = 1'b0;
        while (raw < 65540) begin
            st_exp = ((c % 7) != 0);
            if (c == 6) push("c_stall6", 2, 9'd0, 0, 1, 16'(raw));
            if (c == 7) push("c_ready7", 2, sv(7, 0, 0), 1, 0, 16'(raw));
            if (raw == 65534 && !near_done) begin
                push("c_near", 2, 9'd0, 0, st_exp, 16'(raw));
                near_done = 1'b1;
            end
            step();
            c++;
            raw += int'(st_exp);
        end
        push("c_sat", 2, 9'd0, 0, ((c % 7) != 0), 16'hFFFF); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the MIPS datapath. It is the successor to the fixed two-stage, two-source forwarding unit.
- Tracks in-flight register writes in an internal shift register of DEPTH post-ID stages (stage 1 = EX, stage 2 = MEM, ...).
- Produces a per-source forward select for NUM_SRC read operands.
- Detects load-use hazards, asserts stall and inserts a bubble.
- Counts stall cycles for performance monitoring.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands checked per ID instruction.
- DEPTH, 2, number of tracked post-ID stages (legal range 1..7).
- LOAD_RDY, 2, first stage at which load data can be forwarded (1..DEPTH).
- SEL_W, 3, fwd_sel field width per source. Must satisfy 2^SEL_W > DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src_addr  in  NUM_SRC*ADDR_W  source register addresses; field i is at [i*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  source i is actually read.
- id_dst_addr  in  ADDR_W  destination register of the ID instruction.
- id_wr_en  in  1  ID instruction writes a register.
- id_is_load  in  1  ID instruction is a load.
- hold  in  1  external pipeline freeze (e.g. cache miss).
- flush  in  1  kill the ID instruction and the stage-1 entry.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, s = forward from stage s output.
- stall  out  1  load-use hazard; ID and IF must hold.
- stall_cnt  out  16  saturating count of cycles with stall=1.

Behaviour:
- Entry per stage: valid, wr, load, addr[ADDR_W-1:0].
- Reset: all entries cleared, stall_cnt=0. Resulting outputs are fwd_sel=0 and stall=0. Reset overrides hold and flush.
- Match rule for stage s and source i: id_valid & id_src_used[i] & entry[s].valid & entry[s].wr & (entry[s].addr != 0) & (entry[s].addr == src_i).
- Priority: the lowest matching s (youngest producer) wins, and fwd_sel_i = s. With no match, fwd_sel_i = 0.
- Readiness: the winning entry is ready if it is not a load, or if s >= LOAD_RDY.
- stall = OR over i of (a winning entry exists and it is not ready). When stall=1, fwd_sel values are don't-care but must be stable. Register 0 never causes a match or a stall.
- fwd_sel and stall are combinational from the registered entries and the current ID inputs, giving zero-cycle latency in the ID cycle. No combinational path exists from hold or flush to the outputs.
- Sequential update at posedge clk, in priority order:
  1. rst: clear all.
  2. flush: stage1 <= bubble. Stages 2..DEPTH shift (entry[s] <= entry[s-1]) unless hold=1, in which case they freeze. The ID instruction is discarded.
  3. hold: all entries frozen.
  4. stall: stage1 <= bubble; stages 2..DEPTH shift.
  5. otherwise: stage1 <= {id_valid & id_wr_en, id_is_load, id_dst_addr}; stages 2..DEPTH shift.
- The entry leaving stage DEPTH is dropped. The register file provides write-before-read beyond that point.
- stall_cnt increments on each edge where stall=1 and hold=0 and rst=0. It saturates at 16'hFFFF.
- Simultaneous stall and hold: state frozen and stall stays asserted; the counter does not increment.
- DEPTH=1 is legal. Loads are then never forwardable if LOAD_RDY>1. Elaboration must reject LOAD_RDY>DEPTH.

Decomposition:
- Shared package/include DefVal.v gains `NO_FWD (0) plus the stage-select encoding constants and the default ADDR_W.
- One natural sub-module: fwd_match_src, a per-source priority matcher. It is instantiated NUM_SRC times via generate and outputs sel and not_ready.

Test Plan:
- Back-to-back ALU with default parameters: add r3 then sub uses r3 as src0 → fwd_sel[0]=1, stall=0. One bubble later → fwd_sel[0]=2.
- Load-use: lw r5 then add uses r5 → stall=1 for exactly 1 cycle and bubble in stage 1. Next cycle fwd_sel=2, stall=0, stall_cnt=1.
- Priority: r7 written in stage 1 and stage 2, both sources=r7 → fwd_sel={1,1}. Repeat with src=r0 and a producer writing r0 → fwd_sel=0.
- Hold during load-use stall for 3 cycles → stall held at 1, entries frozen, stall_cnt unchanged. After release → stall_cnt increments once.
- Flush with stage-1 load r4 and dependent ID → next cycle stage 1 is a bubble, stall=0, fwd_sel=0. Assert rst mid-stall → outputs 0 after the edge.
- NUM_SRC=3, DEPTH=4, LOAD_RDY=3: load r9 followed by a dependent read → stall 2 cycles, then fwd_sel=3. Also sweep stall_cnt to saturation at 16'hFFFF.
